// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg: shared timing defaults, colour constants and the sync-word
// layout for the LCD timing controller.
// Optional build macro: LCD_TEST_PATTERN_EN (uses bar_color below).
package lcd_timing_pkg;

   // Width of pixel coordinates and of the raster counters
   localparam int COORD_W = 11;

   // Default 800x480 panel timing (clocks / lines)
   localparam int DEF_H_SYNC  = 128;
   localparam int DEF_H_BP    = 88;
   localparam int DEF_H_ACT   = 800;
   localparam int DEF_H_FP    = 40;
   localparam int DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_ACT + DEF_H_FP;

   localparam int DEF_V_SYNC  = 2;
   localparam int DEF_V_BP    = 33;
   localparam int DEF_V_ACT   = 480;
   localparam int DEF_V_FP    = 10;
   localparam int DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_ACT + DEF_V_FP;

   // Colour constants (24-bit RGB)
   localparam logic [23:0] WHITE   = 24'hFFFFFF;
   localparam logic [23:0] BLACK   = 24'h000000;
   localparam logic [23:0] RED     = 24'hFF0000;
   localparam logic [23:0] YELLOW  = 24'hFFFF00;
   localparam logic [23:0] ORANGE  = 24'hFFA500;
   localparam logic [23:0] GRAY    = 24'h808080;
   localparam logic [23:0] CYAN    = 24'h00FFFF;
   localparam logic [23:0] GREEN   = 24'h00FF00;
   localparam logic [23:0] MAGENTA = 24'hFF00FF;
   localparam logic [23:0] BLUE    = 24'h0000FF;

   // Word carried through the latency-compensation delay line
   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       de;
      logic [9:0] col;
   } sync_word_t;

   localparam int SYNC_W = $bits(sync_word_t);

   // Colour-bar lookup: eight 100-pixel-wide bars across the active line
   function automatic logic [23:0] bar_color(input logic [9:0] col);
      logic [23:0] c;
      if      (col < 10'd100) c = WHITE;
      else if (col < 10'd200) c = YELLOW;
      else if (col < 10'd300) c = CYAN;
      else if (col < 10'd400) c = GREEN;
      else if (col < 10'd500) c = MAGENTA;
      else if (col < 10'd600) c = RED;
      else if (col < 10'd700) c = BLUE;
      else                    c = BLACK;
      return c;
   endfunction

endpackage

// File: rtl/lcd_timing_ctrl_sync_delay.sv
// lcd_sync_delay: fixed-depth shift register that carries the sync/DE word
// alongside the pixel generator's latency. Synchronous clear empties every
// stage so no stale DE survives a reset.
module lcd_sync_delay #(
   parameter int DEPTH = 1,
   parameter int W     = 13
) (
   input  logic         clk_i,
   input  logic         srst_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] stage_q [DEPTH];

   // Shift one stage per clock; clear the whole line on reset
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/lcd_timing_ctrl.sv
// lcd_timing_ctrl: raster timing generator for an RGB panel. Issues pixel
// coordinates to the pixel generator, then lines up hsync/vsync/DE with the
// generator's returned data after a fixed PIX_LAT-cycle latency.
// Optional build macro: LCD_TEST_PATTERN_EN adds pattern_sel, which replaces
// pix_data with eight vertical colour bars.
module lcd_timing_ctrl
   import lcd_timing_pkg::*;
#(
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int H_ACT    = DEF_H_ACT,
   parameter int H_FP     = DEF_H_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int V_ACT    = DEF_V_ACT,
   parameter int V_FP     = DEF_V_FP,
   parameter int PIX_LAT  = 1,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic               clk_in,
   input  logic               sys_rst,
   input  logic [23:0]        pix_data,
`ifdef LCD_TEST_PATTERN_EN
   input  logic               pattern_sel,
`endif
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic               pix_req,
   output logic               lcd_hs,
   output logic               lcd_vs,
   output logic               lcd_de,
   output logic [23:0]        lcd_rgb,
   output logic               frame_start
);

   // Region boundaries expressed at counter width
   localparam logic [COORD_W-1:0] H_TOT_C  = COORD_W'(H_SYNC + H_BP + H_ACT + H_FP);
   localparam logic [COORD_W-1:0] V_TOT_C  = COORD_W'(V_SYNC + V_BP + V_ACT + V_FP);
   localparam logic [COORD_W-1:0] H_SYNC_C = COORD_W'(H_SYNC);
   localparam logic [COORD_W-1:0] V_SYNC_C = COORD_W'(V_SYNC);
   localparam logic [COORD_W-1:0] H_LO_C   = COORD_W'(H_SYNC + H_BP);
   localparam logic [COORD_W-1:0] H_HI_C   = COORD_W'(H_SYNC + H_BP + H_ACT);
   localparam logic [COORD_W-1:0] V_LO_C   = COORD_W'(V_SYNC + V_BP);
   localparam logic [COORD_W-1:0] V_HI_C   = COORD_W'(V_SYNC + V_BP + V_ACT);

   logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
   logic [COORD_W-1:0] v_cnt_q, v_cnt_d;

   logic               hsync_c, vsync_c, active_c;
   logic [COORD_W-1:0] pix_x_d, pix_y_d;

   logic               pix_req_q, frame_start_q, s0_hs_q, s0_vs_q;
   logic [COORD_W-1:0] pix_x_q, pix_y_q;

   sync_word_t         dly_in, dly_out;

   logic               lcd_hs_q, lcd_vs_q, lcd_de_q;
   logic [23:0]        lcd_rgb_q, lcd_rgb_d;

   // Raster counter next state: h wraps at end of line, v advances on h wrap
   always_comb begin
      h_cnt_d = h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_TOT_C - 1'b1) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_TOT_C - 1'b1) ? '0 : v_cnt_q + 1'b1;
      end
   end

   // Raster counters, restarting at (0,0) on reset
   always_ff @(posedge clk_in) begin
      if (sys_rst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // Region decode and coordinate derivation for the current counter value
   always_comb begin
      hsync_c  = (h_cnt_q < H_SYNC_C);
      vsync_c  = (v_cnt_q < V_SYNC_C);
      active_c = (h_cnt_q >= H_LO_C) && (h_cnt_q < H_HI_C) &&
                 (v_cnt_q >= V_LO_C) && (v_cnt_q < V_HI_C);
      pix_x_d  = active_c ? (h_cnt_q - H_LO_C) : '0;
      pix_y_d  = active_c ? (v_cnt_q - V_LO_C) : '0;
   end

   // Stage 0: registered request to the pixel generator plus raw sync flags
   always_ff @(posedge clk_in) begin
      if (sys_rst) begin
         pix_req_q     <= 1'b0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         frame_start_q <= 1'b0;
         s0_hs_q       <= 1'b0;
         s0_vs_q       <= 1'b0;
      end else begin
         pix_req_q     <= active_c;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         frame_start_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
         s0_hs_q       <= hsync_c;
         s0_vs_q       <= vsync_c;
      end
   end

   assign dly_in = '{hs: s0_hs_q, vs: s0_vs_q, de: pix_req_q, col: pix_x_q[9:0]};

   lcd_sync_delay #(
      .DEPTH (PIX_LAT),
      .W     (SYNC_W)
   ) u_sync_delay (
      .clk_i  (clk_in),
      .srst_i (sys_rst),
      .d_i    (dly_in),
      .q_o    (dly_out)
   );

   // Panel RGB source: generator data (or colour bars) only inside the active area
   always_comb begin
      lcd_rgb_d = '0;
      if (dly_out.de) begin
`ifdef LCD_TEST_PATTERN_EN
         lcd_rgb_d = pattern_sel ? bar_color(dly_out.col) : pix_data;
`else
         lcd_rgb_d = pix_data;
`endif
      end
   end

`ifndef LCD_TEST_PATTERN_EN
   // The delayed column only feeds the colour-bar generator
   logic unused_col;
   assign unused_col = ^dly_out.col;
`endif

   // Output stage: apply sync polarity and capture the returned pixel
   always_ff @(posedge clk_in) begin
      if (sys_rst) begin
         lcd_hs_q  <= ~SYNC_POL;
         lcd_vs_q  <= ~SYNC_POL;
         lcd_de_q  <= 1'b0;
         lcd_rgb_q <= '0;
      end else begin
         lcd_hs_q  <= dly_out.hs ^ ~SYNC_POL;
         lcd_vs_q  <= dly_out.vs ^ ~SYNC_POL;
         lcd_de_q  <= dly_out.de;
         lcd_rgb_q <= lcd_rgb_d;
      end
   end

   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign pix_req     = pix_req_q;
   assign frame_start = frame_start_q;
   assign lcd_hs      = lcd_hs_q;
   assign lcd_vs      = lcd_vs_q;
   assign lcd_de      = lcd_de_q;
   assign lcd_rgb     = lcd_rgb_q;

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// tb_lcd_timing_ctrl: three controllers with full horizontal timing and a
// shortened frame (10 lines): PIX_LAT=1/SYNC_POL=0, PIX_LAT=3/SYNC_POL=0 and
// PIX_LAT=1/SYNC_POL=1. A loopback generator returns coordinate-coded data.
// Optional build macro: LCD_TEST_PATTERN_EN (pattern_sel is toggled randomly).
module tb_lcd_timing_ctrl;

   localparam int HS = 128, HB = 88, HA = 800, HF = 40;
   localparam int VS = 2, VB = 3, VA = 4, VF = 1;
   localparam int HT = HS + HB + HA + HF;
   localparam int VT = VS + VB + VA + VF;
   localparam int FR = HT * VT;

   typedef struct packed {
      logic        req;
      logic [10:0] x;
      logic [10:0] y;
      logic        fs;
      logic        hs;
      logic        vs;
      logic        de;
      logic [23:0] rgb;
   } out_t;

   typedef struct {
      int          k;
      logic        req;
      logic [10:0] x;
      logic [10:0] y;
      logic        fs;
      logic        hs;
      logic        vs;
      logic        de;
   } vec_t;

   logic clk;
   logic rst;
   logic psel;
   int   checks;
   int   failures;
   int   k;
   bit   started;
   bit   sel_edge;

   logic [10:0] px_a, py_a, px_b, py_b, px_c, py_c;
   logic        rq_a, hs_a, vs_a, de_a, fs_a;
   logic        rq_b, hs_b, vs_b, de_b, fs_b;
   logic        rq_c, hs_c, vs_c, de_c, fs_c;
   logic [23:0] rgb_a, rgb_b, rgb_c;
   logic [23:0] pd_a = '0, pd_c = '0, pd_b1 = '0, pd_b2 = '0, pd_b = '0;
   out_t        o_a, o_b, o_c;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   lcd_timing_ctrl #(.H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF), .V_SYNC(VS), .V_BP(VB),
                     .V_ACT(VA), .V_FP(VF), .PIX_LAT(1), .SYNC_POL(1'b0)) dut_a (
      .clk_in(clk), .sys_rst(rst), .pix_data(pd_a),
`ifdef LCD_TEST_PATTERN_EN
      .pattern_sel(psel),
`endif
      .pix_x(px_a), .pix_y(py_a), .pix_req(rq_a), .lcd_hs(hs_a), .lcd_vs(vs_a),
      .lcd_de(de_a), .lcd_rgb(rgb_a), .frame_start(fs_a));

   lcd_timing_ctrl #(.H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF), .V_SYNC(VS), .V_BP(VB),
                     .V_ACT(VA), .V_FP(VF), .PIX_LAT(3), .SYNC_POL(1'b0)) dut_b (
      .clk_in(clk), .sys_rst(rst), .pix_data(pd_b),
`ifdef LCD_TEST_PATTERN_EN
      .pattern_sel(psel),
`endif
      .pix_x(px_b), .pix_y(py_b), .pix_req(rq_b), .lcd_hs(hs_b), .lcd_vs(vs_b),
      .lcd_de(de_b), .lcd_rgb(rgb_b), .frame_start(fs_b));

   lcd_timing_ctrl #(.H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF), .V_SYNC(VS), .V_BP(VB),
                     .V_ACT(VA), .V_FP(VF), .PIX_LAT(1), .SYNC_POL(1'b1)) dut_c (
      .clk_in(clk), .sys_rst(rst), .pix_data(pd_c),
`ifdef LCD_TEST_PATTERN_EN
      .pattern_sel(psel),
`endif
      .pix_x(px_c), .pix_y(py_c), .pix_req(rq_c), .lcd_hs(hs_c), .lcd_vs(vs_c),
      .lcd_de(de_c), .lcd_rgb(rgb_c), .frame_start(fs_c));

   assign o_a = {rq_a, px_a, py_a, fs_a, hs_a, vs_a, de_a, rgb_a};
   assign o_b = {rq_b, px_b, py_b, fs_b, hs_b, vs_b, de_b, rgb_b};
   assign o_c = {rq_c, px_c, py_c, fs_c, hs_c, vs_c, de_c, rgb_c};

   // Loopback pixel generators: data = {5'b0, x, y[7:0]} after PIX_LAT clocks
   always @(posedge clk) begin
      pd_a  <= {5'b0, px_a, py_a[7:0]};
      pd_c  <= {5'b0, px_c, py_c[7:0]};
      pd_b1 <= {5'b0, px_b, py_b[7:0]};
      pd_b2 <= pd_b1;
      pd_b  <= pd_b2;
   end

   // Edges since reset release (0 while reset is sampled high)
   always @(posedge clk) begin
      if (rst) begin
         k = 0;
         started = 1'b1;
      end else begin
         k = k + 1;
      end
      sel_edge = psel;
   end

   function automatic logic [23:0] bar_rgb(input int x);
      case (x / 100)
         0: return 24'hFFFFFF;
         1: return 24'hFFFF00;
         2: return 24'h00FFFF;
         3: return 24'h00FF00;
         4: return 24'hFF00FF;
         5: return 24'hFF0000;
         6: return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   function automatic bit in_active(input int h, input int v);
      return (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
   endfunction

   // Reference: raster position p = edges since release; coordinates appear
   // one clock after the position, panel signals PIX_LAT+1 clocks later still.
   function automatic out_t model(input int kk, input int lat, input bit pol, input bit sel);
      out_t e;
      int   p, h, v;
      e = '0;
      e.hs = ~pol;
      e.vs = ~pol;
      if (kk >= 1) begin
         p = (kk - 1) % FR;
         h = p % HT;
         v = p / HT;
         e.req = in_active(h, v);
         if (e.req) begin
            e.x = 11'(h - HS - HB);
            e.y = 11'(v - VS - VB);
         end
         e.fs = (p == 0);
      end
      if (kk >= lat + 2) begin
         p = (kk - 2 - lat) % FR;
         h = p % HT;
         v = p / HT;
         e.hs = (h < HS) ? pol : ~pol;
         e.vs = (v < VS) ? pol : ~pol;
         e.de = in_active(h, v);
         if (e.de) begin
            if (sel) e.rgb = bar_rgb(h - HS - HB);
            else     e.rgb = {5'b0, 11'(h - HS - HB), 8'(v - VS - VB)};
         end
      end
      return e;
   endfunction

   task automatic check_out(input string name, input out_t act, input out_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s k=%0d: got %h required %h", name, k, act, exp);
      end
   endtask

   // Cycle-by-cycle comparison of every instance against the reference
   always @(negedge clk) begin
      if (started) begin
         check_out("model_a", o_a, model(k, 1, 1'b0, sel_edge));
         check_out("model_b", o_b, model(k, 3, 1'b0, sel_edge));
         check_out("model_c", o_c, model(k, 1, 1'b1, sel_edge));
         checks++;
         if ({hs_c, vs_c} !== ~{hs_a, vs_a}) begin
            failures++;
            $display("FAIL sync_pol k=%0d: got hs/vs %b%b required %b%b", k, hs_c, vs_c, ~hs_a, ~vs_a);
         end
      end
   end

   vec_t tbl [17];
   out_t rst_exp0, rst_exp1;

   initial begin
      int guard;
      bit found;
      checks   = 0;
      failures = 0;
      started  = 1'b0;
      k        = 0;
      rst      = 1'b1;
      psel     = 1'b0;

      //             k      req  x        y      fs    hs    vs    de
      tbl[0]  = '{1,     1'b0, 11'd0,   11'd0, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[1]  = '{2,     1'b0, 11'd0,   11'd0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{3,     1'b0, 11'd0,   11'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{130,   1'b0, 11'd0,   11'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{131,   1'b0, 11'd0,   11'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{2114,  1'b0, 11'd0,   11'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{2115,  1'b0, 11'd0,   11'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{5496,  1'b0, 11'd0,   11'd0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{5497,  1'b1, 11'd0,   11'd0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{5499,  1'b1, 11'd2,   11'd0, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[10] = '{6296,  1'b1, 11'd799, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[11] = '{6297,  1'b0, 11'd0,   11'd0, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[12] = '{6299,  1'b0, 11'd0,   11'd0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[13] = '{9464,  1'b1, 11'd799, 11'd3, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[14] = '{10560, 1'b0, 11'd0,   11'd0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[15] = '{10561, 1'b0, 11'd0,   11'd0, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[16] = '{10563, 1'b0, 11'd0,   11'd0, 1'b0, 1'b0, 1'b0, 1'b0};

      rst_exp0 = '0;
      rst_exp0.hs = 1'b1;
      rst_exp0.vs = 1'b1;
      rst_exp1 = '0;

      repeat (4) @(negedge clk);
      check_out("reset_a", o_a, rst_exp0);
      check_out("reset_c", o_c, rst_exp1);

      // Table-driven timing landmarks on instance A after a clean release
      rst = 1'b0;
      foreach (tbl[i]) begin
         guard = 0;
         while (k < tbl[i].k && guard < 20000) begin
            @(negedge clk);
            guard++;
         end
         checks++;
         if (k != tbl[i].k) begin
            failures++;
            $display("FAIL table[%0d] timeout: got k=%0d required k=%0d", i, k, tbl[i].k);
         end else if ({rq_a, px_a, py_a, fs_a, hs_a, vs_a, de_a} !==
                      {tbl[i].req, tbl[i].x, tbl[i].y, tbl[i].fs, tbl[i].hs, tbl[i].vs, tbl[i].de}) begin
            failures++;
            $display("FAIL table[%0d] k=%0d: got req=%b x=%0d y=%0d fs=%b hs=%b vs=%b de=%b required req=%b x=%0d y=%0d fs=%b hs=%b vs=%b de=%b",
                     i, k, rq_a, px_a, py_a, fs_a, hs_a, vs_a, de_a, tbl[i].req, tbl[i].x, tbl[i].y,
                     tbl[i].fs, tbl[i].hs, tbl[i].vs, tbl[i].de);
         end
      end

      // Mid-frame reset while pixel (400,2) is being requested
      found = 1'b0;
      guard = 0;
      while (!found && guard < 25000) begin
         @(negedge clk);
         guard++;
         found = rq_a && (px_a == 11'd400) && (py_a == 11'd2);
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL midreset_wait: got no request for (400,2) required one within 25000 cycles");
      end
      rst = 1'b1;
      @(negedge clk);
      check_out("midreset_a", o_a, rst_exp0);
      check_out("midreset_b", o_b, rst_exp0);
      check_out("midreset_c", o_c, rst_exp1);
      @(negedge clk);
      check_out("midreset_hold_b", o_b, rst_exp0);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (fs_a !== 1'b1 || de_a !== 1'b0 || de_b !== 1'b0) begin
         failures++;
         $display("FAIL restart_fs: got fs=%b de_a=%b de_b=%b required fs=1 de_a=0 de_b=0", fs_a, de_a, de_b);
      end

      // Random run lengths and reset pulses
      repeat (8) begin
         repeat ($urandom_range(2500, 1)) begin
            @(negedge clk);
`ifdef LCD_TEST_PATTERN_EN
            if ($urandom_range(199, 0) == 0) psel = ~psel;
`endif
         end
         rst = 1'b1;
         repeat ($urandom_range(3, 1)) @(negedge clk);
         rst = 1'b0;
      end

      // Long uninterrupted run across two frame wraps
      repeat (22000) begin
         @(negedge clk);
`ifdef LCD_TEST_PATTERN_EN
         if ($urandom_range(299, 0) == 0) psel = ~psel;
`endif
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lcd_timing_ctrl.md
Name: lcd_timing_ctrl

Overview:
- Panel-side timing controller for the calculator LCD: generates hsync/vsync/DE for an 800x480 RGB panel.
- Issues pixel coordinates (pix_x, pix_y) to the pixel generator and captures its returned pix_data into the panel RGB bus, compensating a fixed generator latency.
- Sits between the pixel generator (font/button renderer) and the LCD pins; it is the consumer end of the pix_x/pix_y -> pix_data interface.

Parameters:
- H_SYNC, 128, hsync pulse width (clocks)
- H_BP, 88, horizontal back porch
- H_ACT, 800, active pixels per line
- H_FP, 40, horizontal front porch
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch
- V_ACT, 480, active lines
- V_FP, 10, vertical front porch
- PIX_LAT, 1, cycles from pix_x/pix_y valid to pix_data valid (1..4)
- SYNC_POL, 0, active level of lcd_hs/lcd_vs

Ports:
- clk_in  in  1  pixel clock
- sys_rst  in  1  synchronous reset, active-high
- pix_data  in  24  RGB from pixel generator, valid PIX_LAT cycles after coordinates
- pix_x  out  11  requested column, 0..H_ACT-1
- pix_y  out  11  requested row, 0..V_ACT-1
- pix_req  out  1  coordinates valid (active region)
- lcd_hs  out  1  horizontal sync
- lcd_vs  out  1  vertical sync
- lcd_de  out  1  data enable
- lcd_rgb  out  24  panel RGB
- frame_start  out  1  one-cycle pulse at start of each frame

Behaviour:
- Counters: h_cnt 0..H_TOTAL-1 (H_TOTAL=H_SYNC+H_BP+H_ACT+H_FP=1056); at wrap, v_cnt increments 0..V_TOTAL-1 (525), wrapping to 0. Counters are 11 bits, with no overflow beyond the totals.
- Regions per counter value: hsync when h_cnt<H_SYNC; vsync when v_cnt<V_SYNC; active when H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACT and V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACT.
- Stage 0 (registered, 1 cycle after counter value):
  - pix_req = active.
  - pix_x = h_cnt-(H_SYNC+H_BP) and pix_y = v_cnt-(V_SYNC+V_BP) while active; both 0 when not active.
  - frame_start = 1 when counter is (0,0).
- Delay line: {hsync, vsync, active} is delayed PIX_LAT further cycles after stage 0. On the following edge:
  - lcd_hs = hsync ^ ~SYNC_POL; lcd_vs likewise.
  - lcd_de = delayed active.
  - lcd_rgb = pix_data when delayed active, else 0.
- Total alignment: lcd_de/lcd_rgb at cycle t correspond to pix_x/pix_y presented at cycle t-PIX_LAT-1. The hs/vs/de relationship is identical to undelayed timing, shifted.
- Reset (any cycle, including mid-frame):
  - Counters go to (0,0).
  - Delay line cleared.
  - pix_req=0, pix_x=pix_y=0, lcd_de=0, lcd_rgb=0, frame_start=0.
  - lcd_hs/lcd_vs take their inactive level (~SYNC_POL).
  - The first cycle after release evaluates counter (0,0), so frame_start pulses 1 cycle after release.
- No pix_data qualification exists: data is sampled blindly PIX_LAT cycles after the request, and the generator must meet that latency.
- Line/frame wrap: the last active pixel (799,479) is followed by front porch. There are no bubbles or duplicates at any wrap.

Optional Feature:
- Macro LCD_TEST_PATTERN_EN.
- Defined: adds input pattern_sel (1 bit, after pix_data).
  - When pattern_sel=1, lcd_rgb during active = 8 vertical bars of 100 px, colours in order white, yellow, cyan, green, magenta, red, blue, black.
  - The bar colour is selected from the delayed column, and pix_data is ignored. Timing is unchanged.
- Undefined: no port; lcd_rgb always sourced from pix_data.

Decomposition:
- Package lcd_timing_pkg holds:
  - default timing constants (H_*/V_* and totals);
  - colour constants (WHITE, BLACK, RED, YELLOW, ORANGE, GRAY, bar colours);
  - the coordinate width (11).
- Sub-module lcd_sync_delay: parameterised depth-PIX_LAT shift register carrying {hs, vs, de, col[9:0]} with synchronous clear. The column field is used only under the macro.

Test Plan:
- Reset released at cycle 0 -> frame_start=1 at cycle 1. lcd_hs at active level (SYNC_POL=0 -> low) for 128 clocks per 1056-clock period; lcd_vs low for exactly 2112 clocks per 554400-clock frame.
- First active request -> pix_req rises with pix_x=0, pix_y=0 exactly (35*1056+216)+1 cycles after release. pix_x reaches 799 799 cycles later, and pix_req covers exactly 800x480 cycles per frame.
- Loopback stub pix_data = {5'b0,pix_x[10:0] delayed PIX_LAT, pix_y[7:0]} with PIX_LAT=1 and 3 -> every lcd_de cycle shows lcd_rgb matching the coordinate issued PIX_LAT+1 cycles earlier; lcd_rgb=0 whenever lcd_de=0.
- sys_rst pulsed at pixel (400,200) -> next cycle all outputs are at reset values, no stray lcd_de from in-flight pipeline, and the frame restarts with frame_start 1 cycle after release.
- SYNC_POL=1 -> lcd_hs/lcd_vs inverted relative to the SYNC_POL=0 run, with identical edge positions.
- LCD_TEST_PATTERN_EN, pattern_sel=1 -> columns 0..99 give 24'hFFFFFF, columns 100..199 give 24'hFFFF00, and columns 700..799 give 24'h000000. Toggling pattern_sel to 0 mid-line switches to pix_data on the next pixel.
